// File: rtl/seg595_frame_rx.sv
// Loopback receiver for the 16-bit 7-segment shift-register link: rebuilds the digits the panel shows.
// Optional SEG595_DP_CAPTURE_EN adds a per-digit decimal-point output (dp).
module seg595_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      rclk,
  input  logic                      dio,
  output logic [4*NUM_DIGITS-1:0]   dispnum,
  output logic [15:0]               raw_frame,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic [1:0]                err_code
`ifdef SEG595_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]     dp
`endif
);

  localparam logic [3:0] ND4 = 4'(NUM_DIGITS);

  logic [SYNC_STAGES-1:0] sclk_sync, rclk_sync, dio_sync;
  logic                   sclk_q, rclk_q;
  logic                   sclk_rise, rclk_rise, dio_s;

  logic [15:0] sr, sr_nxt;
  logic [4:0]  bit_cnt, cnt_nxt;
  logic [7:0]  dig, seg_code;
  logic [2:0]  dig_idx;
  logic        dig_ok, seg_ok;
  logic [3:0]  seg_val;
  logic [1:0]  err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      rclk_sync <= '0;
      dio_sync  <= '0;
      sclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      rclk_sync <= {rclk_sync[SYNC_STAGES-2:0], rclk};
      dio_sync  <= {dio_sync[SYNC_STAGES-2:0], dio};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      rclk_q    <= rclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
  assign rclk_rise = rclk_sync[SYNC_STAGES-1] & ~rclk_q;
  assign dio_s     = dio_sync[SYNC_STAGES-1];

  // Shift is resolved before the latch so a coincident sclk/rclk bit lands in this frame.
  assign sr_nxt  = sclk_rise ? {sr[14:0], dio_s} : sr;
  assign cnt_nxt = (sclk_rise && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
  assign dig     = sr_nxt[7:0];
  // seg[k] sits at sr[15-k]; the dp bit (seg[0]) is forced high before lookup.
  assign seg_code = {sr_nxt[8], sr_nxt[9], sr_nxt[10], sr_nxt[11],
                     sr_nxt[12], sr_nxt[13], sr_nxt[14], 1'b1};

  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (dig[i]) dig_idx = 3'(i);
    dig_ok = (dig != 8'h00) && ((dig & (dig - 8'h01)) == 8'h00)
             && ({1'b0, dig_idx} < ND4);
  end

  always_comb begin
    seg_ok  = 1'b1;
    seg_val = 4'hF;
    case (seg_code)
      8'h03:   seg_val = 4'd0;
      8'h9F:   seg_val = 4'd1;
      8'h25:   seg_val = 4'd2;
      8'h0D:   seg_val = 4'd3;
      8'h99:   seg_val = 4'd4;
      8'h49:   seg_val = 4'd5;
      8'h41:   seg_val = 4'd6;
      8'h1F:   seg_val = 4'd7;
      8'h01:   seg_val = 4'd8;
      8'h19:   seg_val = 4'd9;
      8'hFF:   seg_val = 4'hF;
      default: seg_ok  = 1'b0;
    endcase
  end

  always_comb begin
    if (cnt_nxt != 5'd16) err_nxt = 2'b01;
    else if (!dig_ok)     err_nxt = 2'b10;
    else if (!seg_ok)     err_nxt = 2'b11;
    else                  err_nxt = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr          <= '0;
      bit_cnt     <= '0;
      dispnum     <= '1;
      raw_frame   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
`ifdef SEG595_DP_CAPTURE_EN
      dp          <= '0;
`endif
    end else begin
      sr          <= sr_nxt;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (rclk_rise) begin
        bit_cnt     <= 5'd0;
        raw_frame   <= sr_nxt;
        err_code    <= err_nxt;
        frame_valid <= (err_nxt == 2'b00);
        frame_err   <= (err_nxt != 2'b00);
        if (err_nxt == 2'b00) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx == 3'(i)) begin
              dispnum[4*i +: 4] <= seg_val;
`ifdef SEG595_DP_CAPTURE_EN
              dp[i] <= ~sr_nxt[15];
`endif
            end
          end
        end
      end else begin
        bit_cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg595_frame_rx.sv
// Bench for seg595_frame_rx: directed display-link frames plus random frames against a bit-history model.
module tb_seg595_frame_rx;
  localparam int ND = 6;

  logic clk = 1'b0;
  logic rst, sclk, rclk, dio;
  logic [4*ND-1:0] dispnum;
  logic [15:0]     raw_frame;
  logic            frame_valid, frame_err;
  logic [1:0]      err_code;
`ifdef SEG595_DP_CAPTURE_EN
  logic [ND-1:0]   dp;
  logic [ND-1:0]   exp_dp;
`endif

  seg595_frame_rx #(.SYNC_STAGES(2), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
    .dispnum(dispnum), .raw_frame(raw_frame), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_code(err_code)
`ifdef SEG595_DP_CAPTURE_EN
    , .dp(dp)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int nv = 0, ne = 0;
  bit chk_en = 1'b0;

  bit          hist[$];
  int          since;
  logic [3:0]  exp_d [ND];
  logic [1:0]  exp_err;
  logic [15:0] exp_raw;
  bit          exp_good;

  logic [7:0] seg_tab [11] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49,
                               8'h41, 8'h1F, 8'h01, 8'h19, 8'hFF};
  logic [3:0] val_tab [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                               4'd6, 4'd7, 4'd8, 4'd9, 4'hF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [4*ND-1:0] exp_disp();
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = exp_d[i];
    return r;
  endfunction

  // Outside latch windows nothing may pulse and every output must match the model.
  always @(negedge clk) begin
    if (frame_valid) nv++;
    if (frame_err) ne++;
    if (chk_en)
      chk("cycle", {frame_valid, frame_err, err_code, raw_frame, dispnum},
          {2'b00, exp_err, exp_raw, exp_disp()});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_latch();
    int n, p, idx, v;
    logic [15:0] f;
    logic [7:0] sg, dg;
    n = hist.size();
    for (int j = 0; j < 16; j++) begin
      p = n - 16 + j;
      f[15-j] = (p >= 0) ? hist[p] : 1'b0;
    end
    for (int k = 0; k < 8; k++) sg[k] = f[15-k];
    dg = f[7:0];
    idx = -1;
    if ($countones(dg) == 1)
      for (int i = 0; i < 8; i++) if (dg[i]) idx = i;
    v = -1;
    for (int t = 0; t < 11; t++) if (seg_tab[t] == (sg | 8'h01)) v = t;
    exp_raw = f;
    if (since != 16)             exp_err = 2'b01;
    else if (idx < 0 || idx >= ND) exp_err = 2'b10;
    else if (v < 0)              exp_err = 2'b11;
    else begin
      exp_err = 2'b00;
      exp_d[idx] = val_tab[v];
`ifdef SEG595_DP_CAPTURE_EN
      exp_dp[idx] = ~sg[0];
`endif
    end
    exp_good = (exp_err == 2'b00);
    since = 0;
    while (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic send_bit(input bit b);
    dio = b;
    wait_clk(4);
    sclk = 1'b1;
    hist.push_back(b);
    since++;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic do_latch(input bit sim, input bit lastb, input int hold);
    int nv0, ne0;
    chk_en = 1'b0;
    if (sim) begin
      dio = lastb;
      wait_clk(4);
      hist.push_back(lastb);
      since++;
      sclk = 1'b1;
    end
    model_latch();
    nv0 = nv;
    ne0 = ne;
    rclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(hold);
    rclk = 1'b0;
    wait_clk(8);
    chk("pulse_count", (nv - nv0) + (ne - ne0), 1);
    chk("pulse_kind", nv - nv0, exp_good ? 1 : 0);
    chk("err_code", err_code, exp_err);
    chk("raw_frame", raw_frame, exp_raw);
    chk("dispnum", dispnum, exp_disp());
`ifdef SEG595_DP_CAPTURE_EN
    chk("dp", dp, exp_dp);
`endif
    chk_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] seg, input logic [7:0] dig,
                            input bit sim, input int hold);
    bit b [16];
    for (int k = 0; k < 8; k++) b[k] = seg[k];
    for (int k = 0; k < 8; k++) b[8+k] = dig[7-k];
    for (int k = 0; k < 15; k++) send_bit(b[k]);
    if (!sim) send_bit(b[15]);
    do_latch(sim, b[15], hold);
  endtask

  task automatic send_rand_bits(input int n);
    for (int k = 0; k < n; k++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    sclk = 1'b0;
    rclk = 1'b0;
    dio = 1'b0;
    wait_clk(3);
    chk("rst_state", {frame_valid, frame_err, err_code, raw_frame, dispnum},
        {2'b00, 2'b00, 16'h0000, {4*ND{1'b1}}});
`ifdef SEG595_DP_CAPTURE_EN
    chk("rst_dp", dp, '0);
    exp_dp = '0;
`endif
    hist.delete();
    since = 0;
    for (int i = 0; i < ND; i++) exp_d[i] = 4'hF;
    exp_err = 2'b00;
    exp_raw = 16'h0000;
    rst = 1'b0;
    wait_clk(4);
    chk_en = 1'b1;
  endtask

  initial begin
    int ne0, nv0, r, d, v;
    logic [7:0] sg, dg;
    logic [3:0] digs [6] = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};

    do_reset();

    // Single digit 3 at position 2.
    send_frame(8'h0D, 8'h04, 1'b0, 2);
    chk("t1_dispnum", dispnum, 24'hFFF3FF);
    chk("t1_raw", raw_frame, 16'hB004);
    chk("t1_err", err_code, 2'b00);

    // Full scan of 23:59:59.
    nv0 = nv; ne0 = ne;
    for (int k = 0; k < 6; k++) begin
      for (int t = 0; t < 11; t++) if (val_tab[t] == digs[k]) sg = seg_tab[t];
      send_frame(sg, 8'(1 << k), 1'b0, 3);
    end
    chk("t2_dispnum", dispnum, 24'h235959);
    chk("t2_valid_cnt", nv - nv0, 6);
    chk("t2_err_cnt", ne - ne0, 0);

    // Short and long frames.
    send_rand_bits(15);
    do_latch(1'b0, 1'b0, 1);
    chk("t3_err15", err_code, 2'b01);
    chk("t3_disp15", dispnum, 24'h235959);
    send_rand_bits(17);
    do_latch(1'b0, 1'b0, 1);
    chk("t3_err17", err_code, 2'b01);
    chk("t3_disp17", dispnum, 24'h235959);

    // Digit-select and segment errors.
    send_frame(8'h19, 8'h03, 1'b0, 1);
    chk("t4_dig03", err_code, 2'b10);
    send_frame(8'h19, 8'h40, 1'b0, 1);
    chk("t4_dig40", err_code, 2'b10);
    send_frame(8'h55, 8'h01, 1'b0, 1);
    chk("t4_seg55", err_code, 2'b11);
    chk("t4_disp", dispnum, 24'h235959);

    // 16th bit shifted in the same clk as the latch.
    send_frame(8'h99, 8'h02, 1'b1, 2);
    chk("t5_err", err_code, 2'b00);
    chk("t5_dispnum", dispnum, 24'h235949);

    // Reset mid-frame, then a clean frame; rclk held high a long time.
    send_rand_bits(8);
    do_reset();
    send_frame(8'h02, 8'h01, 1'b0, 40);
    chk("t6_dispnum", dispnum, 24'hFFFFF0);
    chk("t6_err", err_code, 2'b00);
`ifdef SEG595_DP_CAPTURE_EN
    chk("t6_dp", dp, 6'b000001);
`endif

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      d = $urandom_range(0, ND - 1);
      v = $urandom_range(0, 10);
      sg = seg_tab[v] & {7'h7F, 1'($urandom_range(0, 1))};
      dg = 8'(1 << d);
      if (r == 5) begin
        send_rand_bits($urandom_range(0, 36));
        do_latch(1'b0, 1'b0, $urandom_range(0, 12));
      end else begin
        if (r == 6) dg = 8'($urandom_range(0, 255));
        if (r == 7) sg = 8'($urandom_range(0, 255));
        send_frame(sg, dg, ($urandom_range(0, 3) == 0), $urandom_range(0, 12));
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
